// File: rtl/tinymos6502_pkg.sv
// Shared phase codes, pin byte layouts and byte builders for the tinymos6502 pin stage.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
//
// Contents: bus_phase_e (2-bit phase code carried on the pins), control-byte and
// status-byte bit positions, and helpers that assemble both bytes.
package tinymos6502_pkg;

    localparam logic [1:0] PHASE_IDLE    = 2'b00;
    localparam logic [1:0] PHASE_ADDR_LO = 2'b01;
    localparam logic [1:0] PHASE_ADDR_HI = 2'b10;
    localparam logic [1:0] PHASE_DATA    = 2'b11;

    typedef enum logic [1:0] {
        BUS_IDLE    = PHASE_IDLE,
        BUS_ADDR_LO = PHASE_ADDR_LO,
        BUS_ADDR_HI = PHASE_ADDR_HI,
        BUS_DATA    = PHASE_DATA
    } bus_phase_e;

    // Control byte on uio_out during the address phases.
    localparam int CTRL_PHASE_MSB = 7;
    localparam int CTRL_PHASE_LSB = 6;
    localparam int CTRL_RW_BIT    = 5;
    localparam int CTRL_SYNC_BIT  = 4;

    // Status byte on uo_out during the data phase.
    localparam int STAT_PHASE_MSB = 7;
    localparam int STAT_PHASE_LSB = 6;
    localparam int STAT_RW_BIT    = 5;
    localparam int STAT_SYNC_BIT  = 4;
    localparam int STAT_WAIT_BIT  = 3;
    localparam int STAT_TMO_BIT   = 2;

    function automatic logic [7:0] ctrl_byte(input bus_phase_e ph, input logic rw,
                                             input logic sync);
        logic [7:0] b;
        b = 8'h00;
        b[CTRL_PHASE_MSB:CTRL_PHASE_LSB] = ph;
        b[CTRL_RW_BIT]                   = rw;
        b[CTRL_SYNC_BIT]                 = sync;
        return b;
    endfunction

    function automatic logic [7:0] status_byte(input logic rw, input logic sync,
                                               input logic waiting, input logic tmo);
        logic [7:0] b;
        b = 8'h00;
        b[STAT_PHASE_MSB:STAT_PHASE_LSB] = PHASE_DATA;
        b[STAT_RW_BIT]                   = rw;
        b[STAT_SYNC_BIT]                 = sync;
        b[STAT_WAIT_BIT]                 = waiting;
        b[STAT_TMO_BIT]                  = tmo;
        return b;
    endfunction

endpackage

// File: rtl/tinymos6502_wait_ctr.sv
// Counts extra DATA clocks while ext_rdy is low and forces completion at MAX_WAIT.
// Latency: done is combinational from ext_rdy and the count register; count and flag update on clk.
// Backpressure: ext_rdy=0 holds the DATA phase, for at most MAX_WAIT extra clocks.
//
// Ports: clk, rst (sync, active-high), in_data (state is DATA), ext_rdy,
//        done (DATA may complete this clk), waiting (DATA held this clk),
//        bus_timeout (sticky: a DATA phase was force-completed).
module tinymos6502_wait_ctr #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic in_data,
    input  logic ext_rdy,
    output logic done,
    output logic waiting,
    output logic bus_timeout
);

    localparam int              CNT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;
    logic             at_max;

    assign at_max      = (cnt_q == CNT_MAX);
    assign done        = ext_rdy || at_max;
    assign waiting     = in_data && !done;
    assign bus_timeout = tmo_q;

    always_comb begin
        cnt_d = cnt_q;
        tmo_d = tmo_q;
        if (in_data) begin
            if (done) begin
                cnt_d = '0;
                // Completion without ready means the limit forced it.
                if (!ext_rdy) begin
                    tmo_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

endmodule

// File: rtl/tinymos6502_bus_mux.sv
// Time-multiplexes the 6502 core bus onto 8 outputs + 8 bidir pins as ADDR_LO -> ADDR_HI -> DATA.
// Latency: 3 clk per bus cycle; core_ce pulses in the completing DATA clk; first pulse in the 4th clk after rst falls.
// Backpressure: none by default; with BUS_WAIT_EN, ext_rdy=0 stretches DATA up to MAX_WAIT extra clocks.
//
// Ports: clk, rst (sync, active-high); core side core_addr/core_dout/core_rw/core_sync in,
//        core_din/core_ce out; pin side uo_out, uio_in, uio_out, uio_oe (FF or 00);
//        ext_rdy (used only with BUS_WAIT_EN); bus_timeout (sticky forced completion).
// Optional feature macro: BUS_WAIT_EN (external ready with wait counter and timeout flag).
module tinymos6502_bus_mux
    import tinymos6502_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_dout,
    input  logic              core_rw,
    input  logic              core_sync,
    output logic [DATA_W-1:0] core_din,
    output logic              core_ce,
    input  logic              ext_rdy,
    output logic [7:0]        uo_out,
    input  logic [7:0]        uio_in,
    output logic [7:0]        uio_out,
    output logic [7:0]        uio_oe,
    output logic              bus_timeout
);

    bus_phase_e        state_q, state_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              in_data;
    logic              data_done;
    logic              waiting;
    logic              timeout;

    assign in_data = (state_q == BUS_DATA);

`ifdef BUS_WAIT_EN
    tinymos6502_wait_ctr #(
        .MAX_WAIT   (MAX_WAIT)
    ) u_wait_ctr (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .ext_rdy    (ext_rdy),
        .done       (data_done),
        .waiting    (waiting),
        .bus_timeout(timeout)
    );
`else
    // DATA always completes in a single clock; ready input has no effect.
    logic unused_ext_rdy;
    localparam int unused_max_wait = MAX_WAIT;
    assign unused_ext_rdy = ext_rdy;
    assign data_done      = 1'b1;
    assign waiting        = 1'b0;
    assign timeout        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        din_d   = din_q;
        case (state_q)
            BUS_IDLE:    state_d = BUS_ADDR_LO;
            BUS_ADDR_LO: state_d = BUS_ADDR_HI;
            BUS_ADDR_HI: state_d = BUS_DATA;
            BUS_DATA: begin
                if (data_done) begin
                    state_d = BUS_ADDR_LO;
                    // Keep the read byte so core_din stays valid after the pins turn around.
                    if (core_rw) begin
                        din_d = uio_in;
                    end
                end
            end
            default:     state_d = BUS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BUS_IDLE;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            din_q   <= din_d;
        end
    end

    // The core advances on exactly the edge that closes the DATA phase.
    assign core_ce     = in_data && data_done;
    // Read data flows straight through during DATA so the core samples it on the ce edge.
    assign core_din    = (in_data && core_rw) ? uio_in : din_q;
    assign bus_timeout = timeout;

    always_comb begin
        uo_out  = 8'h00;
        uio_out = 8'h00;
        uio_oe  = 8'h00;
        case (state_q)
            BUS_ADDR_LO: begin
                uo_out  = core_addr[7:0];
                uio_out = ctrl_byte(state_q, core_rw, core_sync);
                uio_oe  = 8'hFF;
            end
            BUS_ADDR_HI: begin
                uo_out  = core_addr[15:8];
                uio_out = ctrl_byte(state_q, core_rw, core_sync);
                uio_oe  = 8'hFF;
            end
            BUS_DATA: begin
                uo_out = status_byte(core_rw, core_sync, waiting, timeout);
                if (!core_rw) begin
                    uio_out = core_dout;
                    uio_oe  = 8'hFF;
                end
            end
            default: begin
                uo_out  = 8'h00;
                uio_out = 8'h00;
                uio_oe  = 8'h00;
            end
        endcase
    end

endmodule

// File: tb/tb_tinymos6502_bus_mux.sv
// Self-checking bench for tinymos6502_bus_mux: directed per-bus-cycle vectors plus
// hand-written reset, free-run and (with BUS_WAIT_EN) wait/timeout sequences.
module tb_tinymos6502_bus_mux;

    logic        clk;
    logic        rst;
    logic [15:0] core_addr;
    logic [7:0]  core_dout;
    logic        core_rw;
    logic        core_sync;
    logic [7:0]  core_din;
    logic        core_ce;
    logic        ext_rdy;
    logic [7:0]  uo_out;
    logic [7:0]  uio_in;
    logic [7:0]  uio_out;
    logic [7:0]  uio_oe;
    logic        bus_timeout;

    int checks = 0;
    int errors = 0;

    tinymos6502_bus_mux dut (
        .clk        (clk),
        .rst        (rst),
        .core_addr  (core_addr),
        .core_dout  (core_dout),
        .core_rw    (core_rw),
        .core_sync  (core_sync),
        .core_din   (core_din),
        .core_ce    (core_ce),
        .ext_rdy    (ext_rdy),
        .uo_out     (uo_out),
        .uio_in     (uio_in),
        .uio_out    (uio_out),
        .uio_oe     (uio_oe),
        .bus_timeout(bus_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  dout;
        logic        rw;
        logic        sync;
        logic [7:0]  pin_in;
        logic [7:0]  lo_uo;
        logic [7:0]  lo_uio;
        logic [7:0]  hi_uo;
        logic [7:0]  hi_uio;
        logic [7:0]  d_uo;
        logic [7:0]  d_uio;
        logic [7:0]  d_oe;
        logic [7:0]  d_din;
        logic [7:0]  din_after;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int first_ce;
        int last_ce;
        int ce_count;
        logic [1:0] obs_ph;
        logic [1:0] exp_ph;

        //          addr     dout   rw    sync  pin    lo_uo  lo_uio hi_uo  hi_uio d_uo   d_uio  d_oe   d_din  after
        vecs[0] = '{16'hFFFC, 8'h00, 1'b1, 1'b0, 8'h4C, 8'hFC, 8'h60, 8'hFF, 8'hA0, 8'hE0, 8'h00, 8'h00, 8'h4C, 8'h4C};
        vecs[1] = '{16'h0200, 8'h5A, 1'b0, 1'b0, 8'h33, 8'h00, 8'h40, 8'h02, 8'h80, 8'hC0, 8'h5A, 8'hFF, 8'h4C, 8'h4C};
        vecs[2] = '{16'h1234, 8'h00, 1'b1, 1'b1, 8'hA5, 8'h34, 8'h70, 8'h12, 8'hB0, 8'hF0, 8'h00, 8'h00, 8'hA5, 8'hA5};
        vecs[3] = '{16'hABCD, 8'h00, 1'b0, 1'b1, 8'hFF, 8'hCD, 8'h50, 8'hAB, 8'h90, 8'hD0, 8'h00, 8'hFF, 8'hA5, 8'hA5};
        vecs[4] = '{16'h00FF, 8'h00, 1'b1, 1'b0, 8'h00, 8'hFF, 8'h60, 8'h00, 8'hA0, 8'hE0, 8'h00, 8'h00, 8'h00, 8'h00};

        rst       = 1'b1;
        core_addr = 16'h0000;
        core_dout = 8'h00;
        core_rw   = 1'b1;
        core_sync = 1'b0;
        ext_rdy   = 1'b1;
        uio_in    = 8'h00;

        // Reset held for three clocks: all pins quiet, no core enable.
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_uo_out", uo_out, 8'h00);
            chk("rst_uio_oe", uio_oe, 8'h00);
            chk("rst_core_ce", core_ce, 1'b0);
        end
        rst = 1'b0;
        chk("idle_uio_out", uio_out, 8'h00);
        chk("idle_core_din", core_din, 8'h00);

        // One bus cycle per vector; inputs change just after each cycle-opening edge.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            core_addr = vecs[i].addr;
            core_dout = vecs[i].dout;
            core_rw   = vecs[i].rw;
            core_sync = vecs[i].sync;
            uio_in    = vecs[i].pin_in;
            @(negedge clk);
            chk("lo_uo_out", uo_out, vecs[i].lo_uo);
            chk("lo_uio_out", uio_out, vecs[i].lo_uio);
            chk("lo_uio_oe", uio_oe, 8'hFF);
            chk("lo_core_ce", core_ce, 1'b0);
            if (i > 0) chk("held_din_q", core_din, vecs[i-1].din_after);
            @(posedge clk);
            @(negedge clk);
            chk("hi_uo_out", uo_out, vecs[i].hi_uo);
            chk("hi_uio_out", uio_out, vecs[i].hi_uio);
            chk("hi_uio_oe", uio_oe, 8'hFF);
            chk("hi_core_ce", core_ce, 1'b0);
            @(posedge clk);
            @(negedge clk);
            chk("data_uo_out", uo_out, vecs[i].d_uo);
            chk("data_uio_out", uio_out, vecs[i].d_uio);
            chk("data_uio_oe", uio_oe, vecs[i].d_oe);
            chk("data_core_din", core_din, vecs[i].d_din);
            chk("data_core_ce", core_ce, 1'b1);
        end
        @(posedge clk);
        #1;
        core_rw   = 1'b1;
        core_sync = 1'b0;
        core_addr = 16'h0000;
        uio_in    = 8'hC3;
        @(negedge clk);
        chk("last_din_q", core_din, vecs[4].din_after);
        chk("last_phase_lo", uio_out[7:6], 2'b01);

        // Free run of 300 clocks from ADDR_LO: phase order HI, DATA, LO repeating.
        ce_count = 0;
        last_ce  = -1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            obs_ph = (uio_oe == 8'hFF) ? uio_out[7:6] : uo_out[7:6];
            case (c % 3)
                0:       exp_ph = 2'b10;
                1:       exp_ph = 2'b11;
                default: exp_ph = 2'b01;
            endcase
            chk("run_phase", obs_ph, exp_ph);
            if (core_ce) begin
                ce_count++;
                if (last_ce >= 0) chk("run_ce_spacing", c - last_ce, 3);
                last_ce = c;
            end
        end
        chk("run_ce_count", ce_count, 100);

        // Reset in the middle of a write DATA phase (din_q holds C3 from the free run).
        core_rw   = 1'b0;
        core_dout = 8'h5A;
        core_addr = 16'h0200;
        @(posedge clk);
        @(negedge clk);
        chk("wr_hi_uio_out", uio_out, 8'h80);
        @(posedge clk);
        @(negedge clk);
        chk("wr_data_oe", uio_oe, 8'hFF);
        chk("wr_data_dout", uio_out, 8'h5A);
        chk("din_q_before_rst", core_din, 8'hC3);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_uio_oe", uio_oe, 8'h00);
        chk("midrst_core_ce", core_ce, 1'b0);
        chk("midrst_uo_out", uo_out, 8'h00);
        chk("midrst_din_q", core_din, 8'h00);
        rst = 1'b0;

        // First enable lands on the third following negedge (4th clk counting IDLE).
        first_ce = -1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (core_ce) begin
                first_ce = c;
                break;
            end
        end
        chk("first_ce_latency", first_ce, 3);

`ifdef BUS_WAIT_EN
        // ext_rdy low for 5 DATA clocks, then high: DATA lasts 6 clocks, no timeout.
        @(posedge clk);
        #1;
        core_addr = 16'h0000;
        core_rw   = 1'b1;
        uio_in    = 8'h77;
        @(negedge clk);
        @(negedge clk);
        ext_rdy = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("wait_ce_low", core_ce, 1'b0);
            chk("wait_flag", uo_out[3], 1'b1);
        end
        @(posedge clk);
        #1;
        ext_rdy = 1'b1;
        @(negedge clk);
        chk("wait_done_ce", core_ce, 1'b1);
        chk("wait_din", core_din, 8'h77);
        chk("wait_no_timeout", bus_timeout, 1'b0);

        // ext_rdy held low: forced completion on the 16th DATA clock.
        @(posedge clk);
        #1;
        ext_rdy = 1'b0;
        first_ce = -1;
        ce_count = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (uo_out[7:6] == 2'b11) ce_count++;
            if (core_ce) begin
                first_ce = ce_count;
                break;
            end
        end
        chk("forced_data_clks", first_ce, 16);
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            chk("timeout_sticky", bus_timeout, 1'b1);
        end
        ext_rdy = 1'b1;
        rst     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("timeout_cleared", bus_timeout, 1'b0);
        rst = 1'b0;
`else
        chk("no_wait_timeout", bus_timeout, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
